// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
// - state_t  : FSM states of the request sequencer
// - F3_*     : RV32I funct3 size/sign codes for loads and stores
// - f3_legal : 1 when funct3 names a supported access for the direction
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants; loads add BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core-side request/response and memory-side bus of lsu_mem_master.
// - req  : i_req_valid/o_req_ready handshake with we, funct3, byte addr, wdata
// - rsp  : o_rsp_valid/i_rsp_ready handshake with rdata and err
// - mem  : o_mem_we/o_mem_addr/o_mem_wdata out, i_mem_rdata in (combinational)
// modport master is the LSU view, slave is the core + memory environment.
interface lsu_mem_master_if #(parameter int ADDR_W = 8);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [31:0]       i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport master (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for sub-word accesses (purely combinational).
// - word     in  : memory word to extract from / merge into
// - addr_lo  in  : byte offset within the word
// - funct3   in  : RV32I size/sign code
// - wdata    in  : LSB-aligned store data
// - ldata    out : extracted, sign-/zero-extended load value
// - sdata    out : word with the addressed lane replaced (wdata for SW)
// - misalign out : halfword on odd byte, or word not on a word boundary
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] sdata,
  output logic        misalign
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{addr_lo, 3'b000} +: 8];
  assign h = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ldata = word;
    case (funct3)
      F3_B:    ldata = {{24{b[7]}}, b};
      F3_BU:   ldata = {24'd0, b};
      F3_H:    ldata = {{16{h[15]}}, h};
      F3_HU:   ldata = {16'd0, h};
      default: ldata = word;
    endcase
  end

  always_comb begin
    sdata = word;
    case (funct3[1:0])
      2'b00:   sdata[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   sdata[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: sdata = wdata;
    endcase
  end

  // Size code 11 is illegal and flagged by funct3 legality, not here.
  always_comb begin
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator to a word-wide data memory.
// - i_clk, i_rst : clock and synchronous active-high reset
// - bus          : core request/response handshakes and memory port
// Loads and SW take one memory cycle; SB/SH read, merge and write back.
// Errored requests go straight to the response and never touch memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  lsu_mem_master_if.master bus
);
  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              err_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [1:0]  al_addr;
  logic [2:0]  al_f3;
  logic [31:0] ldata, sdata;
  logic        misalign, oor, acc_err;

  // In IDLE the aligner only has to judge the incoming request; afterwards
  // it works on the registered request and captured word.
  assign al_addr = (state == IDLE) ? bus.i_req_addr[1:0] : addr_q[1:0];
  assign al_f3   = (state == IDLE) ? bus.i_req_funct3    : f3_q;

  lsu_align u_align (
    .word     (word_q),
    .addr_lo  (al_addr),
    .funct3   (al_f3),
    .wdata    (wdata_q),
    .ldata    (ldata),
    .sdata    (sdata),
    .misalign (misalign)
  );

  assign oor     = |bus.i_req_addr[31:ADDR_W+2];
  assign acc_err = misalign | oor | ~f3_legal(bus.i_req_we, bus.i_req_funct3);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_req_valid) begin
          we_q        <= bus.i_req_we;
          f3_q        <= bus.i_req_funct3;
          addr_q      <= bus.i_req_addr[ADDR_W+1:0];
          wdata_q     <= bus.i_req_wdata;
          err_q       <= acc_err;
          req_ready_q <= 1'b0;
          if (acc_err) begin
            state       <= RSP;
            rsp_valid_q <= 1'b1;
          end else if (bus.i_req_we && bus.i_req_funct3 == F3_W) begin
            state      <= WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= bus.i_req_addr[ADDR_W+1:2];
          end else begin
            state      <= RD;
            mem_addr_q <= bus.i_req_addr[ADDR_W+1:2];
          end
        end
        RD: begin
          word_q <= bus.i_mem_rdata;
          if (we_q) begin
            state    <= WR;
            mem_we_q <= 1'b1;
          end else begin
            state       <= RSP;
            rsp_valid_q <= 1'b1;
            mem_addr_q  <= '0;
          end
        end
        WR: begin
          state       <= RSP;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          rsp_valid_q <= 1'b1;
        end
        RSP: if (bus.i_rsp_ready) begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = err_q;
  assign bus.o_rsp_rdata = (rsp_valid_q && !err_q && !we_q) ? ldata : '0;
  // Gated by reset so a reset edge during WR commits nothing.
  assign bus.o_mem_we    = mem_we_q & ~i_rst;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_we_q ? sdata : '0;
endmodule
